// File: rtl/seg7_scan_counter_pkg.sv
// rtl/seg7_scan_counter_pkg.sv - shared types, segment constants and decode helpers for the scan counter
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    // Segment patterns, bit6..0 = g..a, active-high.
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg7_decode(input logic [3:0] i_digit);
        logic [6:0] w_seg;
        case (i_digit)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_OFF;
        endcase
        return w_seg;
    endfunction

    // Non-BCD nibbles collapse to 0 so the counter never holds an illegal digit.
    function automatic bcd_t bcd_sanitize(input logic [3:0] i_nibble);
        return (i_nibble > 4'd9) ? 4'd0 : i_nibble;
    endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// rtl/seg7_scan_counter_if.sv - control and display bundle between the host and the scan counter
interface seg7_scan_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  carry;
    logic [6:0]            segments;
    logic [DIGITS-1:0]     digit_sel;

    modport master (
        output en, up, load, load_val,
        input  count_bcd, carry, segments, digit_sel
    );

    modport slave (
        input  en, up, load, load_val,
        output count_bcd, carry, segments, digit_sel
    );
endinterface

// File: rtl/seg7_scan_counter_bcd_cell.sv
// rtl/seg7_scan_counter_bcd_cell.sv - one BCD digit with up/down step, ripple carry/borrow and load
module seg7_bcd_cell
    import seg7_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  bcd_t i_load_val,
    input  logic i_step,
    input  logic i_up,
    output bcd_t o_digit,
    output logic o_step
);
    bcd_t r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= bcd_sanitize(i_load_val);
        end else if (i_step) begin
            if (i_up) begin
                r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
            end
        end
    end

    // Step ripples to the next digit only when this one wraps.
    assign o_step  = i_step && (i_up ? (r_digit == 4'd9) : (r_digit == 4'd0));
    assign o_digit = r_digit;
endmodule

// File: rtl/seg7_scan_counter.sv
// rtl/seg7_scan_counter.sv - prescaled BCD up/down counter driving a multiplexed 7-segment display
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int SCAN_DIV   = 64,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_counter_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    localparam logic [6:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? 7'h7F : SEG_OFF;
    localparam logic [DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]       r_presc;
    logic [SW-1:0]       r_scan_div;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_sel;

    logic                w_tick;
    logic [DIGITS:0]     w_step;
    logic [4*DIGITS-1:0] w_count;
    bcd_t                w_cur_digit;
    logic [DIGITS-1:0]   w_onehot;

    assign w_tick = bus.en && (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (bus.load) begin
            r_presc <= '0;
        end else if (bus.en) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
        end
    end

    assign w_step[0] = w_tick;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_cell
            seg7_bcd_cell u_cell (
                .i_clk      (clk),
                .i_rst      (rst),
                .i_load     (bus.load),
                .i_load_val (bus.load_val[4*g +: 4]),
                .i_step     (w_step[g]),
                .i_up       (bus.up),
                .o_digit    (w_count[4*g +: 4]),
                .o_step     (w_step[g+1])
            );
        end
    endgenerate

    // A step falling out of the top digit is a full wrap; load suppresses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= !bus.load && w_step[DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_div <= '0;
            r_idx      <= '0;
        end else if (r_scan_div == SCAN_LAST) begin
            r_scan_div <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_div <= r_scan_div + 1'b1;
        end
    end

    always_comb begin
        w_cur_digit = '0;
        w_onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_digit = w_count[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Segments and enable share one register stage so they switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_IDLE;
            r_sel <= SEL_IDLE;
        end else if (ACTIVE_LOW != 0) begin
            r_seg <= ~seg7_decode(w_cur_digit);
            r_sel <= ~w_onehot;
        end else begin
            r_seg <= seg7_decode(w_cur_digit);
            r_sel <= w_onehot;
        end
    end

    assign bus.count_bcd = w_count;
    assign bus.carry     = r_carry;
    assign bus.segments  = r_seg;
    assign bus.digit_sel = r_sel;
endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb/tb_seg7_scan_counter.sv - scoreboard bench for seg7_scan_counter, active-high and active-low instances
module tb_seg7_scan_counter;
    localparam int D    = 4;
    localparam int P    = 4;
    localparam int SD   = 2;
    localparam int MAXV = 10000;

    typedef struct {
        int         cnt;
        int         presc;
        int         div;
        int         idx;
        logic       carry;
        logic [6:0] seg;
        logic [3:0] sel;
    } mstate_t;

    typedef struct {
        logic [15:0] cnt;
        logic        carry;
        logic [6:0]  seg;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    mstate_t m = '{default: 0};
    exp_t    exp_q [$];

    always #5 clk = ~clk;

    seg7_scan_counter_if #(.DIGITS(D)) bus ();
    seg7_scan_counter_if #(.DIGITS(D)) bus_al ();

    assign bus_al.en       = bus.en;
    assign bus_al.up       = bus.up;
    assign bus_al.load     = bus.load;
    assign bus_al.load_val = bus.load_val;

    seg7_scan_counter #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(SD), .ACTIVE_LOW(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seg7_scan_counter #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al)
    );

    function automatic int pow10(int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_to_int(logic [15:0] v);
        int r = 0;
        for (int i = 0; i < D; i++) begin
            int n = int'(v[4*i +: 4]);
            if (n > 9) n = 0;
            r = r + n * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(int v);
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic r, logic e, logic u, logic l, logic [15:0] lv);
        mstate_t n = s;
        if (r) return '{default: 0};
        n.seg   = seg_tab[(s.cnt / pow10(s.idx)) % 10];
        n.sel   = 4'(1 << s.idx);
        n.div   = (s.div + 1) % SD;
        if (s.div == SD - 1) n.idx = (s.idx + 1) % D;
        n.carry = 1'b0;
        if (l) begin
            n.cnt   = bcd_to_int(lv);
            n.presc = 0;
        end else if (e) begin
            n.presc = (s.presc + 1) % P;
            if (s.presc == P - 1) begin
                if (u) begin
                    n.cnt   = (s.cnt + 1) % MAXV;
                    n.carry = (s.cnt == MAXV - 1);
                end else begin
                    n.cnt   = (s.cnt + MAXV - 1) % MAXV;
                    n.carry = (s.cnt == 0);
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mstate_t s);
        exp_t x;
        x.cnt   = int_to_bcd(s.cnt);
        x.carry = s.carry;
        x.seg   = s.seg;
        x.sel   = s.sel;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_q.push_back(to_exp(model_next(m, rst, bus.en, bus.up, bus.load, bus.load_val)));
        m <= model_next(m, rst, bus.en, bus.up, bus.load, bus.load_val);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [6:0] inv_seg;
            logic [3:0] inv_sel;
            e       = exp_q.pop_front();
            inv_seg = ~e.seg;
            inv_sel = ~e.sel;
            chk("count_bcd", 32'(bus.count_bcd), 32'(e.cnt));
            chk("carry", 32'(bus.carry), 32'(e.carry));
            chk("segments", 32'(bus.segments), 32'(e.seg));
            chk("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
            chk("al_count_bcd", 32'(bus_al.count_bcd), 32'(e.cnt));
            chk("al_carry", 32'(bus_al.carry), 32'(e.carry));
            chk("al_segments", 32'(bus_al.segments), 32'(inv_seg));
            chk("al_digit_sel", 32'(bus_al.digit_sel), 32'(inv_sel));
        end
    end

    task automatic do_load(logic [15:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    initial begin
        bit found;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (3) @(negedge clk);

        rst    = 1'b0;
        bus.en = 1'b1;
        repeat (40) @(negedge clk);
        chk("ten_ticks", 32'(bus.count_bcd), 32'h0010);

        do_load(16'h9998);
        repeat (10) @(negedge clk);

        bus.up = 1'b0;
        do_load(16'h0000);
        repeat (6) @(negedge clk);

        bus.en = 1'b0;
        do_load(16'h12AF);
        chk("sanitized_load", 32'(bus.count_bcd), 32'h1200);

        do_load(16'h1234);
        repeat (20) @(negedge clk);

        bus.en = 1'b1;
        bus.up = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m.presc == P - 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("tick_align_found", 32'(found), 32'd1);
        do_load(16'h0042);
        chk("load_beats_tick", 32'(bus.count_bcd), 32'h0042);
        repeat (8) @(negedge clk);

        do_load(16'h0777);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(199) == 0);
            bus.en = ($urandom_range(3) != 0);
            bus.up = $urandom_range(1);
            if ($urandom_range(39) == 0) begin
                bus.load = 1'b1;
                case ($urandom_range(3))
                    0:       bus.load_val = 16'h9997;
                    1:       bus.load_val = 16'h0002;
                    default: bus.load_val = 16'($urandom);
                endcase
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
